// File: rtl/inv_sbox_engine.sv
// Iterative inverse 3x3 S-box engine: accepts one block, applies ROUNDS inverse
// substitution passes to every 3-bit group, then holds the result until taken.
module inv_sbox_engine #(
    parameter int DATA_WIDTH = 3,
    parameter int ROUNDS     = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    output logic ready_o,
    input  logic data_i [0:DATA_WIDTH-1],
    output logic valid_o,
    input  logic ready_i,
    output logic data_o [0:DATA_WIDTH-1]
);

    localparam int GROUPS = DATA_WIDTH / 3;
    localparam int CNT_W  = $clog2(ROUNDS + 1);

    if (DATA_WIDTH <= 0 || (DATA_WIDTH % 3) != 0) begin : g_bad_width
        $error("inv_sbox_engine: DATA_WIDTH must be a nonzero multiple of 3");
    end
    if (ROUNDS < 1) begin : g_bad_rounds
        $error("inv_sbox_engine: ROUNDS must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_load;
    logic             r_w   [0:DATA_WIDTH-1];
    logic             w_src [0:DATA_WIDTH-1];
    logic             w_inv [0:DATA_WIDTH-1];

    // The substitution network is shared: it sees data_i only while idle,
    // so input churn during RUN/DONE cannot reach W.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_src
        assign w_src[gi] = (r_state == IDLE) ? data_i[gi] : r_w[gi];
    end

    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_grp
        logic [2:0] w_in;
        logic [2:0] w_out;

        // Packed as {b0, b1, b2} so the case labels read like the b0b1b2 table.
        assign w_in = {w_src[3*gi], w_src[3*gi+1], w_src[3*gi+2]};

        always_comb begin
            w_out = 3'b000;
            case (w_in)
                3'b000: w_out = 3'b101;
                3'b001: w_out = 3'b000;
                3'b010: w_out = 3'b100;
                3'b011: w_out = 3'b110;
                3'b100: w_out = 3'b001;
                3'b101: w_out = 3'b011;
                3'b110: w_out = 3'b111;
                3'b111: w_out = 3'b010;
                default: w_out = 3'b000;
            endcase
        end

        assign w_inv[3*gi]   = w_out[2];
        assign w_inv[3*gi+1] = w_out[1];
        assign w_inv[3*gi+2] = w_out[0];
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_i) begin
                    w_load       = 1'b1;
                    w_cnt_next   = CNT_W'(ROUNDS - 1);
                    w_state_next = (ROUNDS == 1) ? DONE : RUN;
                end
            end
            RUN: begin
                w_load     = 1'b1;
                w_cnt_next = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                r_w[i] <= 1'b0;
            end
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_load) begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    r_w[i] <= w_inv[i];
                end
            end
        end
    end

    assign ready_o = (r_state == IDLE);
    assign valid_o = (r_state == DONE);

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_out
        assign data_o[gi] = r_w[gi];
    end

endmodule

// File: tb/tb_inv_sbox_engine.sv
// Directed bench for inv_sbox_engine: four instances cover the widths and round
// counts needed by the table, latency, backpressure, reset and round-trip scenarios.
module tb_inv_sbox_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Packed views put b0 in the MSB so vectors read as written in the b0b1b2 table.
    logic        a_valid_i = 0, a_ready_i = 1, a_ready_o, a_valid_o;
    logic [2:0]  a_din = '0, a_dout;
    logic        a_data_i [0:2];
    logic        a_data_o [0:2];

    logic        b_valid_i = 0, b_ready_i = 1, b_ready_o, b_valid_o;
    logic [5:0]  b_din = '0, b_dout;
    logic        b_data_i [0:5];
    logic        b_data_o [0:5];

    logic        c_valid_i = 0, c_ready_i = 1, c_ready_o, c_valid_o;
    logic [5:0]  c_din = '0, c_dout;
    logic        c_data_i [0:5];
    logic        c_data_o [0:5];

    logic        d_valid_i = 0, d_ready_i = 1, d_ready_o, d_valid_o;
    logic [11:0] d_din = '0, d_dout;
    logic        d_data_i [0:11];
    logic        d_data_o [0:11];

    always_comb for (int i = 0; i < 3; i++)  begin a_data_i[i] = a_din[2-i];  a_dout[2-i]  = a_data_o[i]; end
    always_comb for (int i = 0; i < 6; i++)  begin b_data_i[i] = b_din[5-i];  b_dout[5-i]  = b_data_o[i]; end
    always_comb for (int i = 0; i < 6; i++)  begin c_data_i[i] = c_din[5-i];  c_dout[5-i]  = c_data_o[i]; end
    always_comb for (int i = 0; i < 12; i++) begin d_data_i[i] = d_din[11-i]; d_dout[11-i] = d_data_o[i]; end

    inv_sbox_engine #(.DATA_WIDTH(3), .ROUNDS(1)) u_a (
        .clk_i(clk), .rst_i(rst), .valid_i(a_valid_i), .ready_o(a_ready_o),
        .data_i(a_data_i), .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o));
    inv_sbox_engine #(.DATA_WIDTH(6), .ROUNDS(2)) u_b (
        .clk_i(clk), .rst_i(rst), .valid_i(b_valid_i), .ready_o(b_ready_o),
        .data_i(b_data_i), .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o));
    inv_sbox_engine #(.DATA_WIDTH(6), .ROUNDS(4)) u_c (
        .clk_i(clk), .rst_i(rst), .valid_i(c_valid_i), .ready_o(c_ready_o),
        .data_i(c_data_i), .valid_o(c_valid_o), .ready_i(c_ready_i), .data_o(c_data_o));
    inv_sbox_engine #(.DATA_WIDTH(12), .ROUNDS(3)) u_d (
        .clk_i(clk), .rst_i(rst), .valid_i(d_valid_i), .ready_o(d_ready_o),
        .data_i(d_data_i), .valid_o(d_valid_o), .ready_i(d_ready_i), .data_o(d_data_o));

    // Hand-written inverse table and its forward counterpart, indexed by b0b1b2.
    logic [2:0] inv_tab [8] = '{3'b101, 3'b000, 3'b100, 3'b110, 3'b001, 3'b011, 3'b111, 3'b010};
    logic [2:0] fwd_tab [8] = '{3'b001, 3'b100, 3'b111, 3'b101, 3'b010, 3'b000, 3'b011, 3'b110};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] fwd12(input logic [11:0] x);
        logic [11:0] y;
        y = x;
        for (int g = 0; g < 4; g++) y[11-3*g -: 3] = fwd_tab[y[11-3*g -: 3]];
        return y;
    endfunction

    task automatic test_reset();
        #1;
        n_vec++;
        if (a_ready_o !== 1'b1 || a_valid_o !== 1'b0 || a_dout !== 3'b000) begin
            n_err++;
            $display("FAIL reset_a: ready=%b valid=%b data=%b, required 1 0 000", a_ready_o, a_valid_o, a_dout);
        end
        n_vec++;
        if (c_ready_o !== 1'b1 || c_valid_o !== 1'b0 || c_dout !== 6'b0) begin
            n_err++;
            $display("FAIL reset_c: ready=%b valid=%b data=%b, required 1 0 000000", c_ready_o, c_valid_o, c_dout);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        $display("reset released at %0t", $time);
    endtask

    task automatic test_inv_table();
        for (int v = 0; v < 8; v++) begin
            a_din = 3'(v);
            a_valid_i = 1'b1;
            tick();
            a_valid_i = 1'b0;
            n_vec++;
            if (a_valid_o !== 1'b1 || a_ready_o !== 1'b0 || a_dout !== inv_tab[v]) begin
                n_err++;
                $display("FAIL inv_table[%b]: valid=%b ready=%b data=%b, required 1 0 %b",
                         3'(v), a_valid_o, a_ready_o, a_dout, inv_tab[v]);
            end else begin
                $display("inv_table %b -> %b", 3'(v), a_dout);
            end
            tick();
            n_vec++;
            if (a_ready_o !== 1'b1 || a_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL inv_handoff[%b]: ready=%b valid=%b, required 1 0", 3'(v), a_ready_o, a_valid_o);
            end
        end
    endtask

    task automatic test_rounds2();
        b_ready_i = 1'b1;
        b_din = 6'b010010;
        b_valid_i = 1'b1;
        tick();
        b_valid_i = 1'b0;
        n_vec++;
        if (b_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL rounds2_early: valid=%b after 1 cycle, required 0", b_valid_o);
        end
        tick();
        n_vec++;
        if (b_valid_o !== 1'b1 || b_dout !== 6'b001001) begin
            n_err++;
            $display("FAIL rounds2_result: valid=%b data=%b, required 1 001001", b_valid_o, b_dout);
        end else begin
            $display("rounds2 010010 -> %b", b_dout);
        end
        tick();
    endtask

    task automatic test_backpressure();
        b_ready_i = 1'b0;
        b_din = 6'b000111;
        b_valid_i = 1'b1;
        tick();
        b_din = 6'b101010;
        tick();
        for (int k = 0; k < 5; k++) begin
            b_din = ~b_din;
            n_vec++;
            if (b_valid_o !== 1'b1 || b_ready_o !== 1'b0 || b_dout !== 6'b011100) begin
                n_err++;
                $display("FAIL backpressure[%0d]: valid=%b ready=%b data=%b, required 1 0 011100",
                         k, b_valid_o, b_ready_o, b_dout);
            end
            tick();
        end
        // valid_i stays high through the handoff edge; it must not be taken there.
        b_ready_i = 1'b1;
        tick();
        b_valid_i = 1'b0;
        n_vec++;
        if (b_ready_o !== 1'b1 || b_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_release: ready=%b valid=%b, required 1 0", b_ready_o, b_valid_o);
        end else begin
            $display("backpressure held 5 cycles, released");
        end
    endtask

    // Runs one ROUNDS=4 block on instance c; optionally churns inputs during RUN.
    task automatic run_c_block(input string name, input bit churn);
        int first_valid;
        c_ready_i = 1'b0;
        c_din = 6'b000001;
        c_valid_i = 1'b1;
        tick();
        c_valid_i = 1'b0;
        first_valid = 0;
        for (int k = 1; k <= 5; k++) begin
            if (c_valid_o === 1'b1 && first_valid == 0) first_valid = k;
            if (churn && c_valid_o !== 1'b1) begin
                c_valid_i = ~c_valid_i;
                c_din = 6'($urandom);
            end
            if (k < 5) tick();
        end
        c_valid_i = 1'b0;
        n_vec++;
        if (first_valid != 4 || c_dout !== 6'b111110) begin
            n_err++;
            $display("FAIL %s: valid rose after %0d cycles data=%b, required 4 cycles 111110", name, first_valid, c_dout);
        end else begin
            $display("%s 000001 -> %b in %0d cycles", name, c_dout, first_valid);
        end
        c_ready_i = 1'b1;
        tick();
        c_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        c_ready_i = 1'b0;
        c_din = 6'b000001;
        c_valid_i = 1'b1;
        tick();
        c_valid_i = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (c_ready_o !== 1'b1 || c_valid_o !== 1'b0 || c_dout !== 6'b0) begin
            n_err++;
            $display("FAIL reset_mid_run: ready=%b valid=%b data=%b, required 1 0 000000", c_ready_o, c_valid_o, c_dout);
        end else begin
            $display("reset mid-run cleared outputs asynchronously");
        end
        tick();
        rst = 1'b0;
        run_c_block("after_reset", 1'b0);
    endtask

    task automatic test_churn();
        run_c_block("churn", 1'b1);
    endtask

    task automatic test_round_trip();
        logic [11:0] pt;
        int bad = 0;
        int waited;
        d_ready_i = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            pt = 12'($urandom);
            d_din = fwd12(fwd12(fwd12(pt)));
            d_valid_i = 1'b1;
            tick();
            d_valid_i = 1'b0;
            waited = 1;
            while (d_valid_o !== 1'b1 && waited < 10) begin
                tick();
                waited++;
            end
            n_vec++;
            if (d_valid_o !== 1'b1 || d_dout !== pt || waited != 3) begin
                n_err++;
                bad++;
                if (bad <= 5)
                    $display("FAIL round_trip[%0d]: valid=%b data=%h after %0d cycles, required 1 %h after 3",
                             n, d_valid_o, d_dout, waited, pt);
            end
            tick();
        end
        $display("round_trip 1000 blocks, %0d wrong", bad);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_inv_table();
        test_rounds2();
        test_backpressure();
        test_reset_mid_run();
        test_churn();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
